uop_issue_scoreboard: RTL

- Issue stage between micro-op decode and execute. It accepts one micro-op per cycle together with its register-usage flags and load indication.
- It holds each op in a single issue register and blocks RAW/WAW hazards on the 16 GPRs and EFLAGS with per-resource busy countdowns.
- It releases ops to execute over a valid/ready handshake. There is no forwarding; consumers wait until the countdown expires.

---
 rtl/uop_issue_scoreboard.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/uop_issue_scoreboard.sv
// rtl/uop_issue_scoreboard.sv - single-entry micro-op issue stage with busy-countdown hazard scoreboard
//
// Purpose: takes one decoded micro-op per cycle into a single issue register and
// releases it to execute over out_valid/out_ready. RAW/WAW hazards on the GPRs and
// EFLAGS are blocked with per-resource 3-bit busy countdowns armed at handoff.
// There is no forwarding: a consumer waits until its producer's countdown expires.
//
// Optional feature macro: ISSUE_STALL_STATS_EN adds stall_cycles / hazard_cycles.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush               drop the op held in the issue register
//   in_valid/in_ready   upstream handshake (in_ready is combinational)
//   in_opcode, in_rd/rs/rt, in_*_gpr, in_*_eflags, in_is_load   incoming op
//   out_valid/out_ready downstream handshake
//   out_opcode, out_rd/rs/rt, out_is_load                        held op
//   stall_cycles        (optional) cycles with in_valid blocked, flush excluded
//   hazard_cycles       (optional) those blocked cycles caused by a hazard
module uop_issue_scoreboard #(
  parameter int NREG     = 16,
  parameter int RIDX_W   = 4,
  parameter int OPCODE_W = 8,
  parameter int ALU_LAT  = 1,
  parameter int LOAD_LAT = 3,
  parameter logic [OPCODE_W-1:0] MICRO_NOP = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPCODE_W-1:0] in_opcode,
  input  logic [RIDX_W-1:0]   in_rd,
  input  logic [RIDX_W-1:0]   in_rs,
  input  logic [RIDX_W-1:0]   in_rt,
  input  logic                in_d_to_gpr,
  input  logic                in_d_from_gpr,
  input  logic                in_s_from_gpr,
  input  logic                in_t_from_gpr,
  input  logic                in_to_eflags,
  input  logic                in_from_eflags,
  input  logic                in_is_load,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OPCODE_W-1:0] out_opcode,
  output logic [RIDX_W-1:0]   out_rd,
  output logic [RIDX_W-1:0]   out_rs,
  output logic [RIDX_W-1:0]   out_rt,
  output logic                out_is_load
`ifdef ISSUE_STALL_STATS_EN
  ,
  output logic [31:0]         stall_cycles,
  output logic [31:0]         hazard_cycles
`endif
);

  localparam logic [2:0] ALU_CNT  = 3'(ALU_LAT);
  localparam logic [2:0] LOAD_CNT = 3'(LOAD_LAT);

  logic [2:0]          cnt_q [NREG];
  logic [2:0]          cnt_d [NREG];
  logic [2:0]          cnt_ef_q, cnt_ef_d;
  logic                out_valid_q, out_valid_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic [RIDX_W-1:0]   rd_q, rd_d, rs_q, rs_d, rt_q, rt_d;
  logic                is_load_q, is_load_d;
  logic                d_to_gpr_q, d_to_gpr_d;
  logic                to_ef_q, to_ef_d;

  logic out_fire, capture, hazard;
  logic rd_busy, rs_busy, rt_busy, ef_busy;

  assign out_fire = out_valid_q & out_ready;

  // The held-op term is kept even when it fires this cycle: its countdown is not
  // armed until the edge, so this closes the one-cycle gap conservatively.
  assign rd_busy = (cnt_q[in_rd] != 3'd0) | (out_valid_q & d_to_gpr_q & (rd_q == in_rd));
  assign rs_busy = (cnt_q[in_rs] != 3'd0) | (out_valid_q & d_to_gpr_q & (rd_q == in_rs));
  assign rt_busy = (cnt_q[in_rt] != 3'd0) | (out_valid_q & d_to_gpr_q & (rd_q == in_rt));
  assign ef_busy = (cnt_ef_q != 3'd0) | (out_valid_q & to_ef_q);

  // Destinations count as sources so a younger write cannot overtake an older one.
  assign hazard = ((in_d_from_gpr | in_d_to_gpr) & rd_busy)
                | (in_s_from_gpr & rs_busy)
                | (in_t_from_gpr & rt_busy)
                | ((in_from_eflags | in_to_eflags) & ef_busy);

  assign in_ready = ~rst & ~flush & ~hazard & (~out_valid_q | out_ready);
  assign capture  = in_valid & in_ready;

  always_comb begin
    opcode_d    = opcode_q;
    rd_d        = rd_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    is_load_d   = is_load_q;
    d_to_gpr_d  = d_to_gpr_q;
    to_ef_d     = to_ef_q;
    out_valid_d = out_valid_q;

    if (capture) begin
      opcode_d   = in_opcode;
      rd_d       = in_rd;
      rs_d       = in_rs;
      rt_d       = in_rt;
      is_load_d  = in_is_load;
      d_to_gpr_d = in_d_to_gpr;
      to_ef_d    = in_to_eflags;
    end

    // capture is already suppressed by flush through in_ready
    if (flush)         out_valid_d = 1'b0;
    else if (capture)  out_valid_d = 1'b1;
    else if (out_fire) out_valid_d = 1'b0;

    // Counters ignore flush: a fire in the same cycle was accepted downstream.
    for (int i = 0; i < NREG; i++) begin
      cnt_d[i] = (cnt_q[i] != 3'd0) ? cnt_q[i] - 3'd1 : 3'd0;
      if (out_fire && d_to_gpr_q && (rd_q == RIDX_W'(i)))
        cnt_d[i] = is_load_q ? LOAD_CNT : ALU_CNT;
    end
    cnt_ef_d = (cnt_ef_q != 3'd0) ? cnt_ef_q - 3'd1 : 3'd0;
    if (out_fire && to_ef_q)
      cnt_ef_d = ALU_CNT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= 3'd0;
      cnt_ef_q    <= 3'd0;
      out_valid_q <= 1'b0;
      opcode_q    <= MICRO_NOP;
      rd_q        <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      is_load_q   <= 1'b0;
      d_to_gpr_q  <= 1'b0;
      to_ef_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= cnt_d[i];
      cnt_ef_q    <= cnt_ef_d;
      out_valid_q <= out_valid_d;
      opcode_q    <= opcode_d;
      rd_q        <= rd_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      is_load_q   <= is_load_d;
      d_to_gpr_q  <= d_to_gpr_d;
      to_ef_q     <= to_ef_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_opcode  = opcode_q;
  assign out_rd      = rd_q;
  assign out_rs      = rs_q;
  assign out_rt      = rt_q;
  assign out_is_load = is_load_q;

`ifdef ISSUE_STALL_STATS_EN
  logic [31:0] stall_q, hazard_cnt_q;
  logic        blocked;

  assign blocked = in_valid & ~in_ready & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q      <= 32'd0;
      hazard_cnt_q <= 32'd0;
    end else begin
      if (blocked)          stall_q      <= stall_q + 32'd1;
      if (blocked & hazard) hazard_cnt_q <= hazard_cnt_q + 32'd1;
    end
  end

  assign stall_cycles  = stall_q;
  assign hazard_cycles = hazard_cnt_q;
`endif

endmodule
